// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin reader for a bank of registered-output FIFOs.
// It issues one read strobe at a time, captures the FIFO word one cycle later and
// presents it on a valid/ready port together with the source index.
// Optional feature macro: FIFO_ARB_BURST_EN. When it is defined, the last source
// may be regranted up to MAX_BURST consecutive words before rotating.
module fifo_drain_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_SRC-1:0]            i_src_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
  input  logic [NUM_SRC-1:0]            i_src_mask,
  output logic [NUM_SRC-1:0]            o_src_rd,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [DATA_WIDTH-1:0]         o_out_data,
  output logic [$clog2(NUM_SRC)-1:0]    o_out_src,
  output logic                          o_busy
);

  localparam int unsigned SrcW = $clog2(NUM_SRC);

  // Elaboration-time parameter sanity checks.
  if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
    $error("fifo_drain_arbiter: NUM_SRC must be in 2..16");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("fifo_drain_arbiter: MAX_BURST must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StRead, StCapt, StHold} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [SrcW-1:0]       r_sel;
  logic [SrcW-1:0]       w_sel_d;
  logic [SrcW-1:0]       r_last;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SrcW-1:0]       r_out_src;

  logic [NUM_SRC-1:0]    w_elig;
  logic                  w_rr_found;
  logic [SrcW-1:0]       w_rr_pick;
  logic [SrcW-1:0]       w_cand;
  int unsigned           w_idx;
  logic [DATA_WIDTH-1:0] w_src_words [NUM_SRC];

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  logic [BurstW-1:0] r_burst;
  logic [BurstW-1:0] w_burst_d;
`endif

  assign w_elig = ~i_src_empty & i_src_mask;

  // Unflatten the FIFO data bus into one word per source.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_src_words[i] = i_src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First eligible source after r_last, scanning upward with wrap-around.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = '0;
    w_cand     = '0;
    w_idx      = 0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      w_idx  = (32'(r_last) + i) % NUM_SRC;
      w_cand = SrcW'(w_idx);
      if (!w_rr_found && w_elig[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = w_cand;
      end
    end
  end

  // Next-state logic: grant in IDLE, then walk READ -> CAPT -> HOLD.
  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
`ifdef FIFO_ARB_BURST_EN
    w_burst_d = r_burst;
`endif
    unique case (r_state)
      StIdle: begin
`ifdef FIFO_ARB_BURST_EN
        if (w_elig[r_last] && (r_burst < BurstW'(MAX_BURST))) begin
          w_state_d = StRead;
          w_sel_d   = r_last;
          w_burst_d = r_burst + BurstW'(1);
        end else if (w_rr_found) begin
          w_state_d = StRead;
          w_sel_d   = w_rr_pick;
          w_burst_d = BurstW'(1);
        end
`else
        if (w_rr_found) begin
          w_state_d = StRead;
          w_sel_d   = w_rr_pick;
        end
`endif
      end
      StRead: w_state_d = StCapt;
      StCapt: w_state_d = StHold;
      StHold: begin
        if (r_out_valid && i_out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State, selected source and burst counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_sel   <= '0;
`ifdef FIFO_ARB_BURST_EN
      r_burst <= '0;
`endif
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
`ifdef FIFO_ARB_BURST_EN
      r_burst <= w_burst_d;
`endif
    end
  end

  // Capture the FIFO word one cycle after the read and hold it until accepted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_last      <= SrcW'(NUM_SRC - 1);
    end else if (r_state == StCapt) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_src_words[r_sel];
      r_out_src   <= r_sel;
      r_last      <= r_sel;
    end else if (r_state == StHold && r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Read strobe decoded from state and selection only, so it stays one-hot.
  always_comb begin
    o_src_rd = '0;
    if (r_state == StRead) begin
      o_src_rd[r_sel] = 1'b1;
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_src   = r_out_src;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: behavioural registered-output FIFOs, a scoreboard
// of expected (source, word) pairs, a vector table and hand-written corner cases.
`timescale 1ns/1ps
module tb_fifo_drain_arbiter;

  localparam int unsigned NSRC = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned MAXB = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NSRC-1:0]   src_empty;
  logic [NSRC*DW-1:0] src_data;
  logic [NSRC-1:0]   src_mask;
  logic [NSRC-1:0]   src_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_src;
  logic              busy;

  always #5 clk = ~clk;

  fifo_drain_arbiter #(
    .NUM_SRC   (NSRC),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAXB)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_src_empty(src_empty),
    .i_src_data (src_data),
    .i_src_mask (src_mask),
    .o_src_rd   (src_rd),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data (out_data),
    .o_out_src  (out_src),
    .o_busy     (busy)
  );

  // Behavioural FIFOs with registered data_out, updated on the read edge.
  logic [DW-1:0] fmem  [NSRC][16];
  int            fwp   [NSRC];
  int            frp   [NSRC];
  logic [DW-1:0] fdout [NSRC];
  logic          push_en   = 1'b0;
  logic          flush     = 1'b0;
  int            push_src  = 0;
  logic [DW-1:0] push_data = '0;
  logic          bad_rd     = 1'b0;
  logic          bad_onehot = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (src_rd[i]) begin
        if (fwp[i] == frp[i]) bad_rd <= 1'b1;
        else begin
          fdout[i] <= fmem[i][frp[i] % 16];
          frp[i]   <= frp[i] + 1;
        end
      end
    end
    if ($countones(src_rd) > 1 || (src_rd != '0 && !busy)) bad_onehot <= 1'b1;
    if (push_en) begin
      fmem[push_src][fwp[push_src] % 16] <= push_data;
      fwp[push_src] <= fwp[push_src] + 1;
    end
    if (flush) begin
      for (int i = 0; i < NSRC; i++) begin
        fwp[i] <= 0;
        frp[i] <= 0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_empty[i]         = (fwp[i] == frp[i]);
      src_data[i*DW +: DW] = fdout[i];
    end
  end

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   xfer_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample handshake at negedge, then return #1 after posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL extra_word: got src %0d data 0x%0h, expected no word", out_src, out_data);
      end else begin
        e = sb.pop_front();
        if (out_src != e.src || out_data != e.data) begin
          n_fail++;
          $display("FAIL out_word: got src %0d data 0x%0h, expected src %0d data 0x%0h",
                   out_src, out_data, e.src, e.data);
        end
        xfer_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int s, input logic [DW-1:0] d);
    push_en   = 1'b1;
    push_src  = s;
    push_data = d;
    cycle();
    push_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic expect_word(input int s, input logic [DW-1:0] d);
    exp_t e;
    e.src  = 2'(s);
    e.data = d;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] s4(input int a, input int b, input int c, input int d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  typedef struct {
    logic [3:0] mask;
    logic [7:0] fill;      // 2-bit word count per source
    int         n;         // words expected out
    logic [7:0] seq_rr;    // 2-bit source per word, strict round-robin
    logic [7:0] seq_burst; // same with burst of 2
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] seq;
    int         k [NSRC];
    int         s;
    int         nf;

    vecs[0] = '{4'b1111, s4(1, 1, 1, 1), 4, s4(0, 1, 2, 3), s4(3, 0, 1, 2)};
    vecs[1] = '{4'b1010, s4(2, 2, 2, 2), 4, s4(1, 3, 1, 3), s4(3, 3, 1, 1)};
    vecs[2] = '{4'b1111, s4(0, 2, 0, 1), 3, s4(1, 3, 1, 0), s4(3, 1, 1, 0)};
    vecs[3] = '{4'b0100, s4(1, 1, 1, 1), 1, s4(2, 0, 0, 0), s4(2, 0, 0, 0)};
    vecs[4] = '{4'b1111, s4(3, 0, 0, 0), 3, s4(0, 0, 0, 0), s4(0, 0, 0, 0)};
    vecs[5] = '{4'b1001, s4(1, 0, 0, 2), 3, s4(0, 3, 3, 0), s4(3, 3, 0, 0)};
    vecs[6] = '{4'b1111, s4(3, 1, 0, 0), 4, s4(0, 1, 0, 0), s4(0, 0, 1, 0)};

    // Reset held with all FIFOs non-empty, then first grant and backpressure.
    out_ready = 1'b0;
`ifdef FIFO_ARB_BURST_EN
    src_mask = 4'b0111;
`else
    src_mask = 4'b1111;
`endif
    rst_n = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < NSRC; i++) push(i, 8'(8'hA0 + i));
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_src_rd", int'(src_rd), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
    end
    check("rst_data", int'(out_data), 0);
    check("rst_src", int'(out_src), 0);
    expect_word(0, 8'hA0);
    rst_n = 1'b1;
    check("rel1_src_rd", int'(src_rd), 0);
    check("rel1_busy", int'(busy), 0);
    cycle();
    check("rel2_src_rd", int'(src_rd), 4'b0001);
    check("rel2_busy", int'(busy), 1);
    cycle();
    check("capt_valid", int'(out_valid), 0);
    check("capt_src_rd", int'(src_rd), 0);
    cycle();
    check("hold_valid", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_data", int'(out_data), 8'hA0);
      check("bp_src", int'(out_src), 0);
      check("bp_src_rd", int'(src_rd), 0);
      check("bp_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    src_mask  = 4'b0000;
    cycle();
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_busy", int'(busy), 0);
    check("bp_sb_empty", sb.size(), 0);

    // Table-driven arbitration scenarios.
    for (int v = 0; v < 7; v++) begin
      src_mask  = '0;
      out_ready = 1'b1;
      do_reset();
      for (int s2 = 0; s2 < NSRC; s2++) begin
        nf = int'(vecs[v].fill[2*s2 +: 2]);
        for (int w = 0; w < nf; w++) push(s2, 8'((s2 + 1) * 16 + w));
      end
`ifdef FIFO_ARB_BURST_EN
      seq = vecs[v].seq_burst;
`else
      seq = vecs[v].seq_rr;
`endif
      for (int j = 0; j < NSRC; j++) k[j] = 0;
      for (int j = 0; j < vecs[v].n; j++) begin
        s = int'(seq[2*j +: 2]);
        expect_word(s, 8'((s + 1) * 16 + k[s]));
        k[s]++;
      end
      xfer_cyc.delete();
      src_mask = vecs[v].mask;
      for (int c = 0; c < vecs[v].n * 4 + 12 && sb.size() != 0; c++) cycle();
      check($sformatf("vec%0d_drain", v), sb.size(), 0);
      sb.delete();
      for (int c = 0; c < 6; c++) cycle();
      for (int j = 1; j < xfer_cyc.size(); j++) begin
        check($sformatf("vec%0d_spacing", v), xfer_cyc[j] - xfer_cyc[j-1], 4);
      end
      for (int s2 = 0; s2 < NSRC; s2++) begin
        check($sformatf("vec%0d_remain%0d", v, s2), fwp[s2] - frp[s2],
              int'(vecs[v].fill[2*s2 +: 2]) - k[s2]);
      end
    end

    // Reset during CAPT: word in flight dropped, arbitration restarts.
    src_mask = '0;
    do_reset();
    push(0, 8'h61);
    push(1, 8'h81);
    push(2, 8'h71);
    push(3, 8'h91);
    expect_word(0, 8'h61);
    expect_word(1, 8'h81);
    src_mask = 4'b0111;
    for (int c = 0; c < 40 && src_rd != 4'b0100; c++) cycle();
    check("mid_read2", int'(src_rd), 4'b0100);
    cycle();
    check("mid_capt_busy", int'(busy), 1);
    check("mid_capt_valid", int'(out_valid), 0);
    rst_n = 1'b0;
    cycle();
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_src_rd", int'(src_rd), 0);
    check("mid_sb_empty", sb.size(), 0);
    check("mid_fifo2_count", fwp[2] - frp[2], 0);
    src_mask = 4'b1111;
    push(0, 8'h62);
    rst_n = 1'b1;
`ifdef FIFO_ARB_BURST_EN
    expect_word(3, 8'h91);
    expect_word(0, 8'h62);
`else
    expect_word(0, 8'h62);
    expect_word(3, 8'h91);
`endif
    for (int c = 0; c < 30 && sb.size() != 0; c++) cycle();
    check("mid_restart_drain", sb.size(), 0);
    src_mask = '0;
    for (int c = 0; c < 6; c++) cycle();

    check("no_read_of_empty", int'(bad_rd), 0);
    check("src_rd_onehot", int'(bad_onehot), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
